// File: rtl/mask_serializer_if.sv
// mask_serializer_if
// Bundles the pattern-FIFO read side, the exposure handshake and the imager
// mask outputs of mask_serializer.
//   fifo_dout/fifo_empty/fifo_valid : pattern FIFO data and status (to serializer)
//   fifo_rd_en                      : one-cycle FIFO read strobe (from serializer)
//   latch_allow                     : exposure FSM ready for a new mask (to serializer)
//   mask_data/mask_sclk/mask_latch  : imager mask lanes, shift strobe, latch pulse
//   busy/underrun/mask_cnt          : status
// modport master is the serializer side, modport slave the surrounding system.
interface mask_serializer_if;
  logic [255:0] fifo_dout;
  logic         fifo_empty;
  logic         fifo_valid;
  logic         fifo_rd_en;
  logic         latch_allow;
  logic [15:0]  mask_data;
  logic         mask_sclk;
  logic         mask_latch;
  logic         busy;
  logic         underrun;
  logic [31:0]  mask_cnt;

  modport master (
    input  fifo_dout, fifo_empty, fifo_valid, latch_allow,
    output fifo_rd_en, mask_data, mask_sclk, mask_latch, busy, underrun, mask_cnt
  );

  modport slave (
    output fifo_dout, fifo_empty, fifo_valid, latch_allow,
    input  fifo_rd_en, mask_data, mask_sclk, mask_latch, busy, underrun, mask_cnt
  );
endinterface

// File: rtl/mask_serializer.sv
// mask_serializer
// Reads 256-bit pattern words from the pattern FIFO and shifts each one out
// over 16 imager mask lanes (16 bits per lane, MSB first), then latches the
// mask once STREAMS_PER_MASK words have gone out and the exposure FSM allows.
// Ports:
//   clk  : sole clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : mask_serializer_if.master (FIFO read side, latch_allow, mask outputs, status)
//
// state        | meaning
// S_IDLE       | between masks, waiting for the FIFO to hold a word
// S_FETCH      | issue one read strobe
// S_WAIT_VALID | wait for the FIFO to return the word
// S_SHIFT      | 16 shift cycles of the captured word
// S_WAIT_WORD  | mid-mask starvation, waiting for a refill
// S_WAIT_LATCH | mask fully shifted, waiting for latch_allow
// S_LATCH      | mask_latch pulse
module mask_serializer #(
  parameter int unsigned STREAMS_PER_MASK = 640,
  parameter int unsigned LATCH_CYCLES     = 4
) (
  input logic             clk,
  input logic             rst,
  mask_serializer_if.master bus
);

  localparam int unsigned SPM = (STREAMS_PER_MASK == 0) ? 1 : STREAMS_PER_MASK;
  localparam int unsigned LC  = (LATCH_CYCLES == 0) ? 1 : LATCH_CYCLES;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_FETCH      = 3'd1,
    S_WAIT_VALID = 3'd2,
    S_SHIFT      = 3'd3,
    S_WAIT_WORD  = 3'd4,
    S_WAIT_LATCH = 3'd5,
    S_LATCH      = 3'd6
  } state_t;

  state_t        state;
  logic [255:0]  shreg;
  logic [3:0]    bit_cnt;
  logic [31:0]   word_cnt;
  logic [31:0]   lat_cnt;
  logic [31:0]   mask_cnt_r;
  logic [15:0]   data_r;
  logic          rd_en_r;
  logic          sclk_r;
  logic          latch_r;
  logic          busy_r;
  logic          underrun_r;

  // Lane i carries word bits [16*i+15 : 16*i]; beat b presents bit 15-b of each lane.
  function automatic logic [15:0] lane_bits(input logic [255:0] w, input logic [3:0] b);
    logic [15:0] r;
    logic [15:0] lane;
    r = '0;
    for (int i = 15; i >= 0; i--) begin
      lane = 16'(w >> (16 * i));
      r    = {r[14:0], lane[4'd15 - b]};
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      lat_cnt    <= '0;
      mask_cnt_r <= '0;
      data_r     <= '0;
      rd_en_r    <= 1'b0;
      sclk_r     <= 1'b0;
      latch_r    <= 1'b0;
      busy_r     <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      rd_en_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!bus.fifo_empty) begin
            state  <= S_FETCH;
            busy_r <= 1'b1;
          end
        end
        S_FETCH: begin
          // Only this block drains the FIFO, so it cannot empty under us;
          // the guard just keeps the strobe off an empty FIFO regardless.
          if (!bus.fifo_empty) begin
            rd_en_r <= 1'b1;
            state   <= S_WAIT_VALID;
          end
        end
        S_WAIT_VALID: begin
          if (bus.fifo_valid) begin
            shreg   <= bus.fifo_dout;
            bit_cnt <= 4'd0;
            data_r  <= lane_bits(bus.fifo_dout, 4'd0);
            sclk_r  <= 1'b1;
            state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (bit_cnt == 4'd15) begin
            sclk_r   <= 1'b0;
            word_cnt <= word_cnt + 32'd1;
            if (word_cnt + 32'd1 >= SPM) begin
              state <= S_WAIT_LATCH;
            end else if (!bus.fifo_empty) begin
              state <= S_FETCH;
            end else begin
              state      <= S_WAIT_WORD;
              underrun_r <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
            data_r  <= lane_bits(shreg, bit_cnt + 4'd1);
          end
        end
        S_WAIT_WORD: begin
          if (!bus.fifo_empty) state <= S_FETCH;
        end
        S_WAIT_LATCH: begin
          if (bus.latch_allow) begin
            state   <= S_LATCH;
            latch_r <= 1'b1;
            lat_cnt <= '0;
          end
        end
        S_LATCH: begin
          if (lat_cnt == 32'(LC - 1)) begin
            latch_r    <= 1'b0;
            mask_cnt_r <= mask_cnt_r + 32'd1;
            word_cnt   <= '0;
            busy_r     <= 1'b0;
            state      <= S_IDLE;
          end else begin
            lat_cnt <= lat_cnt + 32'd1;
          end
        end
        default: begin
          state   <= S_IDLE;
          sclk_r  <= 1'b0;
          latch_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.fifo_rd_en = rd_en_r;
  assign bus.mask_data  = data_r;
  assign bus.mask_sclk  = sclk_r;
  assign bus.mask_latch = latch_r;
  assign bus.busy       = busy_r;
  assign bus.underrun   = underrun_r;
  assign bus.mask_cnt   = mask_cnt_r;

endmodule

// File: tb/tb_mask_serializer.sv
// tb_mask_serializer
// Drives mask_serializer (STREAMS_PER_MASK=2, LATCH_CYCLES=4) from a queue-based
// pattern FIFO and checks every cycle against a transaction-level model: expected
// lane beats per word, 16-beat shift runs, latch acceptance and width, mask count,
// busy, sticky underrun and read-strobe legality. Directed scenarios pin the model
// with hand-computed values; a randomized phase varies word contents, refill gaps
// and latch_allow.
module tb_mask_serializer;
  localparam int SPM = 2;
  localparam int LC  = 4;

  logic clk;
  logic rst;

  mask_serializer_if bus ();

  mask_serializer #(.STREAMS_PER_MASK(SPM), .LATCH_CYCLES(LC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [255:0] fifo_q[$];
  logic         pend;
  logic         rand_allow;

  logic [15:0]  beats[$];
  logic [15:0]  last_data;
  int           run_len, mask_beats, lat_state, lat_n, edges;
  logic [31:0]  model_cnt;
  logic         exp_underrun, idle, rd_prev;
  int           sclk_total, rd_total, latch_hi_total, lane0_n;
  logic [15:0]  lane0_first;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Beat b of a word: lane i shows word bit 16*i+15-b.
  function automatic logic [15:0] beat_of(input logic [255:0] w, input int b);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = w[16*i + 15 - b];
    return r;
  endfunction

  function automatic logic [255:0] rand_word();
    logic [255:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r = {r[223:0], 32'($urandom())};
    return r;
  endfunction

  task automatic monitor();
    logic exp_latch;
    forever begin
      @(posedge clk or posedge rst);
      #1;
      if (rst) begin
        chk("rst_rd_en",    bus.fifo_rd_en, 0);
        chk("rst_sclk",     bus.mask_sclk, 0);
        chk("rst_latch",    bus.mask_latch, 0);
        chk("rst_busy",     bus.busy, 0);
        chk("rst_underrun", bus.underrun, 0);
        chk("rst_data",     bus.mask_data, 0);
        chk("rst_mask_cnt", bus.mask_cnt, 0);
        beats.delete();
        last_data = '0; run_len = 0; mask_beats = 0; lat_state = 0; lat_n = 0;
        edges = 0; model_cnt = '0; exp_underrun = 1'b0; idle = 1'b1; rd_prev = 1'b0;
      end else begin
        edges++;
        if (idle && !bus.fifo_empty) idle = 1'b0;
        // latch: accepted on the first edge latch_allow is seen while waiting
        exp_latch = 1'b0;
        if (lat_state == 1 && bus.latch_allow) begin
          lat_state = 2;
          lat_n     = 0;
        end
        if (lat_state == 2) begin
          lat_n++;
          if (lat_n <= LC) exp_latch = 1'b1;
          else begin
            lat_state = 0;
            model_cnt++;
            mask_beats = 0;
            idle = 1'b1;
          end
        end
        chk("mask_latch", bus.mask_latch, exp_latch);
        if (bus.mask_latch) latch_hi_total++;
        // captured word -> 16 expected beats, first one visible now
        if (bus.fifo_valid) begin
          for (int b = 0; b < 16; b++) beats.push_back(beat_of(bus.fifo_dout, b));
          chk("first_sclk_latency", bus.mask_sclk, 1);
        end
        if (bus.mask_sclk) begin
          chk("sclk_has_word", beats.size() > 0, 1);
          if (beats.size() > 0) chk("mask_data", bus.mask_data, beats.pop_front());
          if (lane0_n < 16) begin
            lane0_first = {lane0_first[14:0], bus.mask_data[0]};
            lane0_n++;
          end
          run_len++;
          mask_beats++;
          sclk_total++;
          last_data = bus.mask_data;
        end else begin
          chk("mask_data_hold", bus.mask_data, last_data);
          if (run_len != 0) begin
            chk("sclk_run_len", run_len, 16);
            run_len = 0;
            if (mask_beats >= 16 * SPM) lat_state = 1;
            else if (bus.fifo_empty) exp_underrun = 1'b1;
          end
        end
        if (bus.fifo_rd_en) begin
          rd_total++;
          chk("rd_nonempty",     bus.fifo_empty, 0);
          chk("rd_not_latching", lat_state != 0, 0);
          chk("rd_single",       rd_prev, 0);
          chk("rd_after_rst",    edges >= 2, 1);
        end
        rd_prev = bus.fifo_rd_en;
        chk("busy",     bus.busy, !idle);
        chk("underrun", bus.underrun, exp_underrun);
        chk("mask_cnt", bus.mask_cnt, model_cnt);
      end
    end
  endtask

  // FIFO: a word returns with fifo_valid one cycle after the strobe cycle.
  task automatic tick();
    @(negedge clk);
    if (rand_allow) bus.latch_allow = ($urandom_range(0, 2) == 0);
    if (rst) begin
      pend = 1'b0;
      bus.fifo_valid = 1'b0;
    end else begin
      if (pend && fifo_q.size() > 0) begin
        bus.fifo_dout  = fifo_q.pop_front();
        bus.fifo_valid = 1'b1;
      end else begin
        bus.fifo_valid = 1'b0;
      end
      pend = bus.fifo_rd_en;
    end
    bus.fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic push(input logic [255:0] w);
    fifo_q.push_back(w);
    bus.fifo_empty = 1'b0;
  endtask

  task automatic wait_cnt(input logic [31:0] target, input string name);
    int n = 0;
    while (bus.mask_cnt !== target && n < 3000) begin
      tick();
      n++;
    end
    chk(name, bus.mask_cnt, target);
  endtask

  task automatic wait_sclk(input int target, input string name);
    int n = 0;
    while (!(sclk_total == target && !bus.mask_sclk) && n < 500) begin
      tick();
      n++;
    end
    chk(name, sclk_total, target);
  endtask

  initial begin
    logic [255:0] w;
    int n;
    rst = 1'b1;
    rand_allow = 1'b0;
    pend = 1'b0;
    bus.fifo_dout = '0;
    bus.fifo_empty = 1'b1;
    bus.fifo_valid = 1'b0;
    bus.latch_allow = 1'b0;
    last_data = '0; run_len = 0; mask_beats = 0; lat_state = 0; lat_n = 0; edges = 0;
    model_cnt = '0; exp_underrun = 1'b0; idle = 1'b1; rd_prev = 1'b0;
    sclk_total = 0; rd_total = 0; latch_hi_total = 0; lane0_n = 0; lane0_first = '0;
    fork
      monitor();
    join_none
    repeat (3) tick();
    rst = 1'b0;

    // one mask, two back-to-back words, lane 0 of the first word = A5C3
    bus.latch_allow = 1'b1;
    w = rand_word();
    w[15:0] = 16'hA5C3;
    push(w);
    push(rand_word());
    wait_cnt(32'd1, "mask1_done");
    chk("lane0_serial",   lane0_first, 16'hA5C3);
    chk("mask1_rd_count", rd_total, 2);
    chk("mask1_sclks",    sclk_total, 32);
    chk("mask1_latch_w",  latch_hi_total, 4);
    chk("mask1_underrun", bus.underrun, 0);

    // latch held off for 50 cycles after the final shift
    bus.latch_allow = 1'b0;
    push(rand_word());
    push(rand_word());
    wait_sclk(64, "mask2_shifted");
    repeat (50) tick();
    chk("hold_busy",     bus.busy, 1);
    chk("hold_no_latch", latch_hi_total, 4);
    chk("hold_no_read",  rd_total, 4);
    bus.latch_allow = 1'b1;
    tick();
    chk("latch_follows", bus.mask_latch, 1);
    wait_cnt(32'd2, "mask2_done");

    // starvation after the first word of a mask
    push(rand_word());
    wait_sclk(80, "mask3_word0");
    repeat (5) tick();
    chk("underrun_set", bus.underrun, 1);
    chk("starved_busy", bus.busy, 1);
    push(rand_word());
    wait_cnt(32'd3, "mask3_done");
    chk("underrun_sticky", bus.underrun, 1);
    chk("mask3_sclks",     sclk_total, 96);

    // reset on the 8th beat (bit_cnt=7), then a clean mask from bit 15
    push(rand_word());
    n = 0;
    while (run_len != 8 && n < 200) begin
      tick();
      n++;
    end
    chk("reach_bit7", run_len, 8);
    rst = 1'b1;
    tick();
    tick();
    chk("after_rst_cnt",  bus.mask_cnt, 0);
    chk("after_rst_data", bus.mask_data, 0);
    rst = 1'b0;
    push(rand_word());
    push(rand_word());
    wait_cnt(32'd1, "mask_after_rst");

    // randomized contents, refill gaps and latch_allow
    rand_allow = 1'b1;
    for (int m = 0; m < 20; m++) begin
      for (int k = 0; k < SPM; k++) begin
        repeat ($urandom_range(0, 25)) tick();
        push(rand_word());
      end
    end
    rand_allow = 1'b0;
    bus.latch_allow = 1'b1;
    wait_cnt(32'd21, "random_masks_done");

    // mask counter wrap
    repeat (3) tick();
    force dut.mask_cnt_r = 32'hFFFF_FFFF;
    model_cnt = 32'hFFFF_FFFF;
    tick();
    release dut.mask_cnt_r;
    tick();
    chk("preset_cnt", bus.mask_cnt, 32'hFFFF_FFFF);
    push(rand_word());
    push(rand_word());
    wait_cnt(32'd0, "mask_cnt_wrap");

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mask_serializer.md
MASK_SERIALIZER -- requirements
Module: mask_serializer

Interface
REQ-001 SHALL have parameter STREAMS_PER_MASK, default 640, giving the number of 256-bit words per mask (subframe); a value of 0 SHALL behave as 1.
REQ-002 SHALL have parameter LATCH_CYCLES, default 4, giving the mask_latch pulse width in clk cycles; a value of 0 SHALL behave as 1.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have port fifo_dout, input, 256, pattern word from the pattern FIFO written by the load_pattern stage.
REQ-006 SHALL have port fifo_empty, input, 1, pattern FIFO empty.
REQ-007 SHALL have port fifo_valid, input, 1, fifo_dout valid, one cycle after fifo_rd_en.
REQ-008 SHALL have port fifo_rd_en, output, 1, registered one-cycle read strobe.
REQ-009 SHALL have port latch_allow, input, 1, exposure FSM ready to accept a new mask.
REQ-010 SHALL have port mask_data, output, 16, one bit per imager mask lane.
REQ-011 SHALL have port mask_sclk, output, 1, shift strobe; mask_data is valid while it is high.
REQ-012 SHALL have port mask_latch, output, 1, mask latch pulse to the imager.
REQ-013 SHALL have port busy, output, 1, high in every state except S_IDLE.
REQ-014 SHALL have port underrun, output, 1, sticky starvation flag.
REQ-015 SHALL have port mask_cnt, output, 32, number of completed masks.

Function
REQ-016 SHALL implement the states S_IDLE, S_FETCH, S_WAIT_VALID, S_SHIFT, S_WAIT_WORD, S_WAIT_LATCH and S_LATCH, plus a word counter word_cnt and a bit counter bit_cnt of 0..15.
REQ-017 In S_IDLE, when fifo_empty=0, the block SHALL go to S_FETCH.
REQ-018 In S_FETCH, fifo_rd_en SHALL be high for exactly one cycle, then the block SHALL go to S_WAIT_VALID.
REQ-019 Exactly one fifo_rd_en pulse SHALL be issued per word; fifo_rd_en SHALL never be asserted while fifo_empty=1.
REQ-020 In S_WAIT_VALID, when fifo_valid=1, the block SHALL capture fifo_dout into a shift register, clear bit_cnt and go to S_SHIFT.
REQ-021 fifo_valid in any state other than S_WAIT_VALID SHALL be ignored.
REQ-022 In S_SHIFT, each cycle SHALL drive mask_sclk=1 and mask_data[i] = word[16*i+15-bit_cnt] for i = 0..15 (MSB first per lane), for 16 consecutive cycles.
REQ-023 Outside S_SHIFT, mask_sclk SHALL be 0 and mask_data SHALL hold its last value.
REQ-024 After the 16th shift of a word, the block SHALL increment word_cnt.
REQ-025 After that increment, if word_cnt reaches STREAMS_PER_MASK the block SHALL go to S_WAIT_LATCH.
REQ-026 Otherwise, if fifo_empty=0 the block SHALL go to S_FETCH, and if fifo_empty=1 it SHALL go to S_WAIT_WORD and set underrun=1.
REQ-027 In S_WAIT_WORD, the block SHALL go to S_FETCH when fifo_empty=0; underrun SHALL stay set until rst.
REQ-028 An empty FIFO in S_IDLE, i.e. between masks, SHALL NOT set underrun.
REQ-029 In S_WAIT_LATCH, the block SHALL go to S_LATCH on the first cycle latch_allow=1.
REQ-030 If latch_allow is already high when S_WAIT_LATCH is entered, S_LATCH SHALL be entered on the next cycle.
REQ-031 In S_LATCH, mask_latch SHALL be high for exactly LATCH_CYCLES cycles.
REQ-032 On the last S_LATCH cycle, the block SHALL increment mask_cnt (wrapping from 2^32-1 to 0), clear word_cnt and go to S_IDLE.
REQ-033 The block SHALL NOT read any FIFO words during S_WAIT_LATCH or S_LATCH.
REQ-034 Latency: the first mask_sclk SHALL occur in the cycle after fifo_valid is captured.
REQ-035 Unreachable state encodings SHALL return to S_IDLE on the next clock.

Reset
REQ-036 Assertion of rst SHALL immediately force state=S_IDLE and fifo_rd_en, mask_sclk, mask_latch, busy and underrun to 0.
REQ-037 Assertion of rst SHALL immediately clear mask_data, mask_cnt, word_cnt, bit_cnt and the shift register.
REQ-038 rst asserted mid-shift or mid-latch SHALL abort the operation without completing it; a partially shifted mask SHALL NOT be latched.
REQ-039 After rst deasserts, the first fifo_rd_en SHALL occur no earlier than the second rising edge.

Verification
REQ-040 Single word, STREAMS_PER_MASK=1, fifo_dout lane 0 = 16'hA5C3, latch_allow=1 -> lane 0 serial output 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1 on 16 mask_sclk cycles; mask_latch high for 4 cycles; mask_cnt=1.
REQ-041 STREAMS_PER_MASK=2 with 2 words back-to-back -> exactly 2 fifo_rd_en pulses, 32 mask_sclk cycles and 1 latch pulse.
REQ-042 latch_allow held 0 for 50 cycles after the final shift -> no mask_latch, no fifo_rd_en, busy=1; latch_allow rises -> mask_latch follows on the next cycle.
REQ-043 FIFO empties after word 1 of 2 -> S_WAIT_WORD with underrun=1; refill -> shifting resumes; underrun remains 1.
REQ-044 rst pulsed during bit_cnt=7 -> all outputs 0 immediately; mask_cnt=0; the next word shifts from bit 15.
REQ-045 mask_cnt preset via 2^32-1 completed masks (or forced) followed by one more mask -> mask_cnt=0.
